// File: rtl/rv_mem_pkg.sv
// Shared memory-access definitions: opcodes, funct3 width codes, LSU state encoding
// and the misalignment rule used by the optional trap.
package rv_mem_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } lsu_state_t;

   // funct3[1:0]: 00 byte, 01 half, anything else behaves as a word.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = a[0];
         default: is_misaligned = (a != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: funct3 and the low address bits select byte enables, replicate
// store data across lanes and extract/extend the loaded value from the read word.
import rv_mem_pkg::*;

module lsu_lane_align (
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_en   = 4'b0000;
      wdata     = 32'h0;
      load_data = 32'h0;
      byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
      half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         2'b01: begin
            // Halfword lane chosen by a[1] only; a[0] is dropped here.
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{store_data[15:0]}};
            load_data = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         default: begin
            byte_en   = 4'b1111;
            wdata     = store_data;
            load_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack bus transaction per load/store with timeout abort.
// Define MISALIGN_TRAP_EN to reject misaligned H/W accesses with bus_error instead of issuing them.
import rv_mem_pkg::*;

module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] read_address,
   input  logic [31:0] write_address,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd_in,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_byte_en,
   output logic        bus_read,
   output logic        bus_write,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        stall,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic [4:0]  load_rd,
   output logic        bus_error,
   output logic [1:0]  lsu_state
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_t  state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [31:0] addr_q, data_q;
   logic [2:0]  f3_q;
   logic [4:0]  rd_q;
   logic        store_q;

   logic        is_load_op, is_store_op, mem_op, trap;
   logic        req_ok, req_timeout;
   logic [31:0] sel_addr, ld_ext, wdata_al;
   logic [3:0]  be_al;

   assign is_load_op  = (opcode == OP_LOAD);
   assign is_store_op = (opcode == OP_STORE);
   assign mem_op      = is_load_op | is_store_op;
   assign sel_addr    = is_store_op ? write_address : read_address;

`ifdef MISALIGN_TRAP_EN
   assign trap = mem_op & is_misaligned(funct3, sel_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   assign req_ok      = (state == S_REQ) & bus_ack;
   assign req_timeout = (state == S_REQ) & ~bus_ack & (cnt == CNT_LAST);

   lsu_lane_align u_align (
      .funct3     (f3_q),
      .addr_lo    (addr_q[1:0]),
      .store_data (data_q),
      .rdata      (bus_rdata),
      .byte_en    (be_al),
      .wdata      (wdata_al),
      .load_data  (ld_ext)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         S_IDLE: begin
            if (mem_op) begin
               cnt_d   = '0;
               state_d = trap ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            // An ack on the last counted cycle still wins over the timeout.
            if (bus_ack || cnt == CNT_LAST) state_d = S_DONE;
            else                           cnt_d   = cnt + CW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q     <= 32'h0;
         data_q     <= 32'h0;
         f3_q       <= 3'b000;
         rd_q       <= 5'd0;
         store_q    <= 1'b0;
         load_valid <= 1'b0;
         load_data  <= 32'h0;
         load_rd    <= 5'd0;
         bus_error  <= 1'b0;
      end else begin
         if (state == S_IDLE && mem_op) begin
            addr_q  <= sel_addr;
            data_q  <= store_data;
            f3_q    <= funct3;
            rd_q    <= rd_in;
            store_q <= is_store_op;
         end
         load_valid <= req_ok & ~store_q;
         if (req_ok && !store_q) begin
            load_data <= ld_ext;
            load_rd   <= rd_q;
         end
         bus_error <= req_timeout | ((state == S_IDLE) & trap);
      end
   end

   assign bus_addr    = {addr_q[31:2], 2'b00};
   assign bus_read    = (state == S_REQ) & ~store_q;
   assign bus_write   = (state == S_REQ) & store_q;
   assign bus_byte_en = (state == S_REQ) ? be_al : 4'b0000;
   assign bus_wdata   = (state == S_REQ) ? wdata_al : 32'h0;
   assign stall       = rst & ((state == S_REQ) | ((state == S_IDLE) & mem_op));
   assign lsu_state   = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drivers push expected bus requests, load results
// and error pulses (with their cycle) into queues; a negedge monitor pops and compares.
import rv_mem_pkg::*;

module tb_load_store_unit;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [6:0]  opcode = 7'h0;
   logic [2:0]  funct3 = 3'h0;
   logic [31:0] read_address = 32'h0, write_address = 32'h0, store_data = 32'h0;
   logic [4:0]  rd_in = 5'h0;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_byte_en;
   logic        bus_read, bus_write;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        stall, load_valid, bus_error;
   logic [31:0] load_data;
   logic [4:0]  load_rd;
   logic [1:0]  lsu_state;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
      .read_address(read_address), .write_address(write_address),
      .store_data(store_data), .rd_in(rd_in),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
      .bus_read(bus_read), .bus_write(bus_write), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall(stall), .load_valid(load_valid), .load_data(load_data), .load_rd(load_rd),
      .bus_error(bus_error), .lsu_state(lsu_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [68:0] exp_bus_q[$];
   int          exp_bus_cyc_q[$];
   logic [36:0] exp_ld_q[$];
   int          exp_ld_cyc_q[$];
   int          exp_err_cyc_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s act=event exp=none (cycle %0d)", name, cyc);
   endtask

   // monitor
   logic prev_strobe = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         prev_strobe = 1'b0;
      end else begin
         if ((bus_read | bus_write) && !prev_strobe) begin
            if (exp_bus_q.size() == 0) unexpected("bus_req");
            else begin
               chk("bus_req", {bus_write, bus_addr, bus_byte_en, bus_write ? bus_wdata : 32'h0},
                   exp_bus_q.pop_front());
               chk("bus_req_cycle", cyc, exp_bus_cyc_q.pop_front());
            end
         end
         prev_strobe = bus_read | bus_write;
         if (load_valid) begin
            if (exp_ld_q.size() == 0) unexpected("load_valid");
            else begin
               chk("load_result", {load_rd, load_data}, exp_ld_q.pop_front());
               chk("load_cycle", cyc, exp_ld_cyc_q.pop_front());
            end
         end
         if (bus_error) begin
            if (exp_err_cyc_q.size() == 0) unexpected("bus_error");
            else chk("bus_error_cycle", cyc, exp_err_cyc_q.pop_front());
         end
      end
   end

   // driver: ack_k = cycle of ack relative to issue (0 = never ack)
   task automatic do_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [4:0] rd, input int ack_k,
                            input logic [31:0] rdata, input logic [31:0] exp_ld,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
      int  c0;
      logic st;
      st = (op == OP_STORE);
      @(posedge clk); #1;
      c0 = cyc;
      opcode = op; funct3 = f3; read_address = addr; write_address = addr;
      store_data = sdata; rd_in = rd;
      exp_bus_q.push_back({st, addr[31:2], 2'b00, exp_be, st ? exp_wd : 32'h0});
      exp_bus_cyc_q.push_back(c0 + 1);
      if (!st && ack_k > 0) begin
         exp_ld_q.push_back({rd, exp_ld});
         exp_ld_cyc_q.push_back(c0 + ack_k + 1);
      end
      if (ack_k == 0) exp_err_cyc_q.push_back(c0 + T + 1);
      #1 chk("stall_issue", stall, 1'b1);
      @(posedge clk); #1;
      opcode = 7'h0;
      chk("stall_req", stall, 1'b1);
      if (ack_k > 0) begin
         while (cyc < c0 + ack_k) begin @(posedge clk); #1; end
         chk("strobe_at_ack", st ? bus_write : bus_read, 1'b1);
         bus_ack = 1'b1; bus_rdata = rdata;
         @(posedge clk); #1;
         bus_ack = 1'b0; bus_rdata = 32'h0;
      end else begin
         while (cyc < c0 + T + 1) begin @(posedge clk); #1; end
      end
      chk("stall_done", stall, 1'b0);
      chk("strobe_done", {bus_read, bus_write}, 2'b00);
      @(posedge clk); #1;
   endtask

   int c0;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {bus_addr, bus_wdata, bus_byte_en, bus_read, bus_write, stall,
                            load_valid, load_data, load_rd, bus_error}, 110'h0);
      chk("reset_state", lsu_state, S_IDLE);
      @(posedge clk); #1 rst = 1'b1;

      // no-op opcode: nothing happens
      opcode = 7'b0110011;
      #1 chk("stall_nop", stall, 1'b0);
      repeat (2) @(posedge clk);
      #1 chk("state_nop", lsu_state, S_IDLE);
      opcode = 7'h0;

      do_access(OP_LOAD,  F3_LW,  32'h100, 32'h0,        5'd5, 3, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h0);
      do_access(OP_LOAD,  F3_LB,  32'h103, 32'h0,        5'd6, 1, 32'h80123456, 32'hFFFFFF80, 4'b1000, 32'h0);
      do_access(OP_LOAD,  F3_LBU, 32'h103, 32'h0,        5'd7, 2, 32'h80123456, 32'h00000080, 4'b1000, 32'h0);
      do_access(OP_STORE, F3_LH,  32'h202, 32'h0000ABCD, 5'd8, 2, 32'h0,        32'h0,        4'b1100, 32'hABCDABCD);
      do_access(OP_LOAD,  F3_LH,  32'h102, 32'h0,        5'd9, 1, 32'h80123456, 32'hFFFF8012, 4'b1100, 32'h0);
      do_access(OP_LOAD,  F3_LHU, 32'h100, 32'h0,       5'd10, 2, 32'h8012F456, 32'h0000F456, 4'b0011, 32'h0);
      do_access(OP_LOAD,  F3_LB,  32'h101, 32'h0,       5'd11, 1, 32'h00007F00, 32'h0000007F, 4'b0010, 32'h0);
      do_access(OP_STORE, F3_LB,  32'h301, 32'h123456A5, 5'd0, 1, 32'h0,        32'h0,        4'b0010, 32'hA5A5A5A5);
      do_access(OP_STORE, F3_LW,  32'h400, 32'h12345678, 5'd0, 4, 32'h0,        32'h0,        4'b1111, 32'h12345678);
      do_access(OP_LOAD,  3'b011, 32'h104, 32'h0,       5'd12, 1, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 32'h0);
      // timeout, then ack landing exactly on the timeout cycle
      do_access(OP_LOAD,  F3_LW,  32'h500, 32'h0,       5'd13, 0, 32'h0,        32'h0,        4'b1111, 32'h0);
      do_access(OP_LOAD,  F3_LW,  32'h504, 32'h0,       5'd14, T, 32'h0BADF00D, 32'h0BADF00D, 4'b1111, 32'h0);

`ifdef MISALIGN_TRAP_EN
      @(posedge clk); #1;
      c0 = cyc;
      opcode = OP_LOAD; funct3 = F3_LW; read_address = 32'h101; rd_in = 5'd15;
      exp_err_cyc_q.push_back(c0 + 1);
      #1 chk("stall_trap_issue", stall, 1'b1);
      @(posedge clk); #1;
      opcode = 7'h0;
      chk("stall_trap", stall, 1'b0);
      chk("no_read_trap", bus_read, 1'b0);
      @(posedge clk); #1;
`else
      do_access(OP_LOAD, F3_LW, 32'h101, 32'h0, 5'd15, 2, 32'h11223344, 32'h11223344, 4'b1111, 32'h0);
`endif

      // reset while a load is in S_REQ: dropped, later ack ignored
      @(posedge clk); #1;
      c0 = cyc;
      opcode = OP_LOAD; funct3 = F3_LW; read_address = 32'h600; rd_in = 5'd16;
      exp_bus_q.push_back({1'b0, 32'h600, 4'b1111, 32'h0});
      exp_bus_cyc_q.push_back(c0 + 1);
      @(posedge clk); #1;
      opcode = 7'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("reset_inflight_outputs", {bus_addr, bus_wdata, bus_byte_en, bus_read, bus_write, stall,
                                     load_valid, load_data, load_rd, bus_error}, 110'h0);
      chk("reset_inflight_state", lsu_state, S_IDLE);
      @(posedge clk); #1 rst = 1'b1;
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      repeat (2) begin
         @(posedge clk); #1;
         chk("ack_after_reset_state", lsu_state, S_IDLE);
      end
      bus_ack = 1'b0; bus_rdata = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      chk("exp_bus_drained", exp_bus_q.size(), 0);
      chk("exp_ld_drained", exp_ld_q.size(), 0);
      chk("exp_err_drained", exp_err_cyc_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
